axi_lite_rd_arbiter: RTL

- Two-master, one-slave AXI-lite read-channel arbiter between the fetch unit (instruction reads) and the load/store unit (data reads), in front of the shared AXI-lite RAM read port.
- Grants one read transaction at a time, AR handshake through R handshake, with round-robin fairness on ties.
- Write channels do not pass through this block; they connect LSU to RAM directly.

---
 rtl/axi_lite_rd_arbiter_if.sv | 24 ++
 rtl/axi_lite_rd_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/axi_lite_rd_arbiter_if.sv
// AXI-lite read channel bundle (AR + R) shared by both masters and the slave port.
// The master modport drives the address and rready; the slave modport answers.
interface axi_lite_rd_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_rd_arbiter.sv
// Two-master (IFU, LSU) to one-slave AXI-lite read arbiter, one transaction at a time.
// Ties go round-robin; the grant is registered, costing one IDLE cycle per transaction.
module axi_lite_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    axi_lite_rd_arbiter_if.slave          ifu,
    axi_lite_rd_arbiter_if.slave          lsu,
    axi_lite_rd_arbiter_if.master         s
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        AR_IFU = 3'd1,
        R_IFU  = 3'd2,
        AR_LSU = 3'd3,
        R_LSU  = 3'd4
    } state_e;

    localparam logic GRANT_IFU = 1'b0;
    localparam logic GRANT_LSU = 1'b1;

    state_e state_q;
    state_e state_d;
    logic   last_grant_q;
    logic   last_grant_d;

    // State and round-robin history registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_IFU;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next-state: arbitration in IDLE, handshake tracking in AR/R.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (ifu.arvalid && lsu.arvalid) begin
                    state_d = (last_grant_q == GRANT_LSU) ? AR_IFU : AR_LSU;
                end else if (lsu.arvalid) begin
                    state_d = AR_LSU;
                end else if (ifu.arvalid) begin
                    state_d = AR_IFU;
                end else begin
                    state_d = IDLE;
                end
            end
            AR_IFU: begin
                if (ifu.arvalid && s.arready) begin
                    state_d      = R_IFU;
                    last_grant_d = GRANT_IFU;
                end else if (!ifu.arvalid) begin
                    // Request withdrawn before acceptance: abandon without touching history.
                    state_d = IDLE;
                end else begin
                    state_d = AR_IFU;
                end
            end
            R_IFU: begin
                if (s.rvalid && ifu.rready) begin
                    state_d = IDLE;
                end else begin
                    state_d = R_IFU;
                end
            end
            AR_LSU: begin
                if (lsu.arvalid && s.arready) begin
                    state_d      = R_LSU;
                    last_grant_d = GRANT_LSU;
                end else if (!lsu.arvalid) begin
                    state_d = IDLE;
                end else begin
                    state_d = AR_LSU;
                end
            end
            R_LSU: begin
                if (s.rvalid && lsu.rready) begin
                    state_d = IDLE;
                end else begin
                    state_d = R_LSU;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: pass-through muxing selected by state, everything zero otherwise.
    always_comb begin
        s.araddr    = {ADDR_W{1'b0}};
        s.arvalid   = 1'b0;
        s.rready    = 1'b0;
        ifu.arready = 1'b0;
        ifu.rdata   = {DATA_W{1'b0}};
        ifu.rresp   = 2'b00;
        ifu.rvalid  = 1'b0;
        lsu.arready = 1'b0;
        lsu.rdata   = {DATA_W{1'b0}};
        lsu.rresp   = 2'b00;
        lsu.rvalid  = 1'b0;
        case (state_q)
            IDLE: begin
            end
            AR_IFU: begin
                s.araddr    = ifu.araddr;
                s.arvalid   = ifu.arvalid;
                ifu.arready = s.arready;
            end
            R_IFU: begin
                ifu.rdata  = s.rdata;
                ifu.rresp  = s.rresp;
                ifu.rvalid = s.rvalid;
                s.rready   = ifu.rready;
            end
            AR_LSU: begin
                s.araddr    = lsu.araddr;
                s.arvalid   = lsu.arvalid;
                lsu.arready = s.arready;
            end
            R_LSU: begin
                lsu.rdata  = s.rdata;
                lsu.rresp  = s.rresp;
                lsu.rvalid = s.rvalid;
                s.rready   = lsu.rready;
            end
            default: begin
            end
        endcase
    end

endmodule
